// File: rtl/divclock_pkg.sv
// Shared types and default limits for the divided-clock monitor.
package divclock_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    LOCKED
  } state_t;

  localparam int unsigned DEF_MIN_PERIOD = 3;
  localparam int unsigned DEF_MAX_PERIOD = 4;
  localparam int unsigned DEF_LOCK_COUNT = 8;

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchronizer plus history flop; flags a rising edge of din in the clk domain.
module sync_rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/divclock_monitor.sv
// Measures divclock periods in fullclock cycles, tracks lock and counts bad periods and stalls.
module divclock_monitor
  import divclock_pkg::*;
#(
  parameter int unsigned MIN_PERIOD = DEF_MIN_PERIOD,
  parameter int unsigned MAX_PERIOD = DEF_MAX_PERIOD,
  parameter int unsigned LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int unsigned CNT_WIDTH  = 8,
  parameter int unsigned ERR_WIDTH  = 16
) (
  input  logic                 fullclock,
  input  logic                 reset,
  input  logic                 divclock,
  input  logic                 clear_errors,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 period_valid,
  output logic                 locked,
  output logic [ERR_WIDTH-1:0] error_count
);

  localparam int unsigned GR_WIDTH = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_WIDTH-1:0] P_MIN = CNT_WIDTH'(MIN_PERIOD);
  localparam logic [CNT_WIDTH-1:0] P_MAX = CNT_WIDTH'(MAX_PERIOD);
  localparam logic [CNT_WIDTH-1:0] P_TO  = CNT_WIDTH'(MAX_PERIOD + 1);
  localparam logic [GR_WIDTH-1:0]  GR_LOCK = GR_WIDTH'(LOCK_COUNT);

  logic                 rise;
  logic [CNT_WIDTH-1:0] cnt;
  state_t               state, state_n;
  logic [GR_WIDTH-1:0]  good_run, good_run_n;
  logic [CNT_WIDTH-1:0] period_n;
  logic                 pv_n, locked_n, err_inc, in_window;
  logic [ERR_WIDTH-1:0] err_n;

  sync_rise_detect u_sync (
    .clk   (fullclock),
    .reset (reset),
    .din   (divclock),
    .rise  (rise)
  );

  always_ff @(posedge fullclock) begin
    if (reset)
      cnt <= '0;
    else if (rise)
      cnt <= CNT_WIDTH'(1);
    else if (cnt != '1)
      cnt <= cnt + CNT_WIDTH'(1);
  end

  always_comb begin
    state_n    = state;
    good_run_n = good_run;
    period_n   = period;
    pv_n       = 1'b0;
    locked_n   = locked;
    err_inc    = 1'b0;
    in_window  = (cnt >= P_MIN) && (cnt <= P_MAX);
    case (state)
      IDLE: begin
        if (rise) begin
          state_n    = MEASURE;
          good_run_n = '0;
        end
      end
      MEASURE, LOCKED: begin
        // A rise wins over the timeout, so a rise at MAX_PERIOD+1 is one bad period.
        if (rise) begin
          pv_n     = 1'b1;
          period_n = cnt;
          if (in_window) begin
            if (good_run != GR_LOCK)
              good_run_n = good_run + GR_WIDTH'(1);
            if (state == MEASURE && good_run_n == GR_LOCK) begin
              state_n  = LOCKED;
              locked_n = 1'b1;
            end
          end else begin
            good_run_n = '0;
            err_inc    = 1'b1;
            locked_n   = 1'b0;
            state_n    = MEASURE;
          end
        end else if (cnt == P_TO) begin
          err_inc    = 1'b1;
          good_run_n = '0;
          locked_n   = 1'b0;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (clear_errors)
      err_n = err_inc ? ERR_WIDTH'(1) : '0;
    else if (err_inc && error_count != '1)
      err_n = error_count + ERR_WIDTH'(1);
    else
      err_n = error_count;
  end

  always_ff @(posedge fullclock) begin
    if (reset) begin
      state        <= IDLE;
      good_run     <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      error_count  <= '0;
    end else begin
      state        <= state_n;
      good_run     <= good_run_n;
      period       <= period_n;
      period_valid <= pv_n;
      locked       <= locked_n;
      error_count  <= err_n;
    end
  end

endmodule

// File: tb/tb_divclock_monitor.sv
// Directed bench for divclock_monitor; divclock is driven on falling fullclock edges.
module tb_divclock_monitor;

  localparam int unsigned EW = 8;  // narrow error counter so saturation is reachable quickly

  logic          fullclock;
  logic          reset;
  logic          divclock;
  logic          clear_errors;
  logic [7:0]    period;
  logic          period_valid;
  logic          locked;
  logic [EW-1:0] error_count;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ridx     = 1;

  typedef struct {
    int   due;
    logic epv;
    int   eper;
    logic elk;
    int   eerr;
    int   idx;
  } exp_t;

  exp_t q[$];

  divclock_monitor #(
    .MIN_PERIOD (3),
    .MAX_PERIOD (4),
    .LOCK_COUNT (8),
    .CNT_WIDTH  (8),
    .ERR_WIDTH  (EW)
  ) dut (
    .fullclock    (fullclock),
    .reset        (reset),
    .divclock     (divclock),
    .clear_errors (clear_errors),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .error_count  (error_count)
  );

  initial fullclock = 1'b0;
  always #5 fullclock = ~fullclock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic state_chk(input string tag, input logic elk, input int eerr);
    chk({tag, "_locked"}, 32'(locked), 32'(elk));
    chk({tag, "_err"}, 32'(error_count), 32'(eerr));
  endtask

  // Advance to the next falling edge and check any expectation falling due there.
  task automatic tick();
    exp_t e;
    @(negedge fullclock);
    cyc++;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk($sformatf("pv_r%0d", e.idx), 32'(period_valid), 32'(e.epv));
      if (e.epv)
        chk($sformatf("period_r%0d", e.idx), 32'(period), 32'(e.eper));
      chk($sformatf("locked_r%0d", e.idx), 32'(locked), 32'(e.elk));
      chk($sformatf("err_r%0d", e.idx), 32'(error_count), 32'(e.eerr));
    end else begin
      chk($sformatf("no_pv_c%0d", cyc), 32'(period_valid), 32'(0));
    end
  endtask

  // One divclock rise followed by gap cycles until the next drive point.
  task automatic rise(input int gap, input logic epv, input int eper, input logic elk,
                      input int eerr, input logic clr);
    exp_t e;
    e.due  = cyc + 3;
    e.epv  = epv;
    e.eper = eper;
    e.elk  = elk;
    e.eerr = eerr;
    e.idx  = ridx;
    q.push_back(e);
    ridx++;
    divclock = 1'b1;
    for (int i = 1; i <= gap; i++) begin
      tick();
      if (i == 1) divclock = 1'b0;
      if (clr && i == 2) clear_errors = 1'b1;
      if (clr && i == 3) clear_errors = 1'b0;
    end
  endtask

  initial begin
    reset        = 1'b1;
    divclock     = 1'b0;
    clear_errors = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_pv", 32'(period_valid), 32'(0));
    chk("rst_period", 32'(period), 32'(0));
    state_chk("rst", 1'b0, 0);

    // Alternating 3/4 after reset: lock on the 8th measured period.
    for (int k = 1; k <= 9; k++)
      rise((k % 2 == 1) ? 3 : 4, k > 1, (k % 2 == 0) ? 3 : 4, k == 9, 0, 1'b0);

    // Period of 2 while locked, then relock.
    rise(2, 1'b1, 3, 1'b1, 0, 1'b0);
    rise(3, 1'b1, 2, 1'b0, 1, 1'b0);
    for (int k = 12; k <= 19; k++)
      rise((k == 19) ? 7 : ((k % 2 == 1) ? 3 : 4), 1'b1, (k % 2 == 0) ? 3 : 4, k == 19, 1, 1'b0);

    // Stall: timeout five cycles after the last rise was seen, counted once.
    state_chk("stall_before", 1'b1, 1);
    tick();
    state_chk("stall_timeout", 1'b0, 2);
    repeat (100) tick();
    state_chk("stall_hold", 1'b0, 2);

    // Resume from IDLE: first rise is only a reference.
    for (int k = 20; k <= 28; k++)
      rise((k % 2 == 0) ? 3 : 4, k > 20, (k % 2 == 1) ? 3 : 4, k == 28, 2, 1'b0);
    rise(2, 1'b1, 3, 1'b1, 2, 1'b0);

    // Repeated bad periods drive the counter into saturation.
    for (int k = 30; k <= 290; k++)
      rise(2, 1'b1, 2, 1'b0, ((k - 27) > 255) ? 255 : (k - 27), 1'b0);

    // Clear together with a bad period leaves exactly one error.
    rise(4, 1'b1, 2, 1'b0, 1, 1'b1);
    rise(5, 1'b1, 4, 1'b0, 1, 1'b0);
    // Rise exactly at count MAX_PERIOD+1: one bad period, no extra timeout.
    rise(3, 1'b1, 5, 1'b0, 2, 1'b0);
    rise(3, 1'b1, 3, 1'b0, 2, 1'b0);

    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    state_chk("clear_alone", 1'b0, 0);
    repeat (3) tick();
    state_chk("measure_pre_to", 1'b0, 0);
    tick();
    state_chk("measure_to", 1'b0, 1);

    for (int k = 295; k <= 303; k++)
      rise((k % 2 == 1) ? 3 : 4, k > 295, (k % 2 == 0) ? 3 : 4, k == 303, 1, 1'b0);

    // Reset while locked and mid-period.
    tick();
    state_chk("pre_reset", 1'b1, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_period", 32'(period), 32'(0));
    state_chk("mid_rst", 1'b0, 0);
    rise(3, 1'b0, 0, 1'b0, 0, 1'b0);
    rise(4, 1'b1, 3, 1'b0, 0, 1'b0);
    rise(3, 1'b1, 4, 1'b0, 0, 1'b0);

    if (q.size() != 0)
      chk("pending_expectations", 32'(q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
